// File: rtl/issue_queue.sv
// Parametrised issue queue: captures dispatched ops, snoops CDB broadcasts to wake pending
// operands, and issues the lowest-index ready entries to up to NUM_ISSUE execution ports.
module issue_queue #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned NUM_ISSUE   = 2,
  parameter int unsigned NUM_CDB     = 2,
  parameter int unsigned ROB_ADDR_W  = 2,
  parameter int unsigned DEST_W      = 6,
  parameter int unsigned OP_W        = 6,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           disp_valid,
  output logic                           disp_ready,
  input  logic [ROB_ADDR_W-1:0]          disp_rob_addr,
  input  logic [DEST_W-1:0]              disp_dest,
  input  logic [OP_W-1:0]                disp_op,
  input  logic                           disp_qj_busy,
  input  logic                           disp_qk_busy,
  input  logic [ROB_ADDR_W-1:0]          disp_qj,
  input  logic [ROB_ADDR_W-1:0]          disp_qk,
  input  logic [DATA_W-1:0]              disp_vj,
  input  logic [DATA_W-1:0]              disp_vk,
  input  logic [DATA_W-1:0]              disp_a,
  input  logic [NUM_CDB-1:0]             cdb_valid,
  input  logic [NUM_CDB*ROB_ADDR_W-1:0]  cdb_rob_addr,
  input  logic [NUM_CDB*DATA_W-1:0]      cdb_value,
  output logic [NUM_ISSUE-1:0]           issue_valid,
  input  logic [NUM_ISSUE-1:0]           issue_ready,
  output logic [NUM_ISSUE*ROB_ADDR_W-1:0] issue_rob_addr,
  output logic [NUM_ISSUE*DEST_W-1:0]    issue_dest,
  output logic [NUM_ISSUE*OP_W-1:0]      issue_op,
  output logic [NUM_ISSUE*DATA_W-1:0]    issue_vj,
  output logic [NUM_ISSUE*DATA_W-1:0]    issue_vk,
  output logic [NUM_ISSUE*DATA_W-1:0]    issue_a,
  output logic [$clog2(NUM_ENTRIES):0]   occupancy
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef struct packed {
    logic                  valid;
    logic [ROB_ADDR_W-1:0] rob_addr;
    logic [DEST_W-1:0]     dest;
    logic [OP_W-1:0]       op;
    logic                  qj_busy;
    logic [ROB_ADDR_W-1:0] qj;
    logic [DATA_W-1:0]     vj;
    logic                  qk_busy;
    logic [ROB_ADDR_W-1:0] qk;
    logic [DATA_W-1:0]     vk;
    logic [DATA_W-1:0]     a;
  } entry_t;

  entry_t                 ent_q [NUM_ENTRIES];
  entry_t                 ent_d [NUM_ENTRIES];
  logic [CNT_W-1:0]       count_q, count_d;
  logic [NUM_ENTRIES-1:0] ready;
  logic [NUM_ISSUE-1:0]   sel_valid;
  logic [IDX_W-1:0]       sel_idx [NUM_ISSUE];
  logic [IDX_W-1:0]       free_idx;
  logic                   disp_fire;

  // Returns {hit, value} for a tag; lowest CDB index wins on duplicate tags.
  function automatic logic [DATA_W:0] snoop(input logic [ROB_ADDR_W-1:0]         tag,
                                            input logic [NUM_CDB-1:0]            cv,
                                            input logic [NUM_CDB*ROB_ADDR_W-1:0] ct,
                                            input logic [NUM_CDB*DATA_W-1:0]     cval);
    logic [DATA_W:0] res;
    res = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (cv[c] && (ct[c*ROB_ADDR_W +: ROB_ADDR_W] == tag)) begin
        res = {1'b1, cval[c*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  assign disp_ready = !rst && (count_q < CNT_W'(NUM_ENTRIES));
  assign disp_fire  = disp_valid && disp_ready;
  assign occupancy  = count_q;

  // Ready vector and lowest-index free slot, from registered state only.
  always_comb begin
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      ready[i] = ent_q[i].valid && !ent_q[i].qj_busy && !ent_q[i].qk_busy;
      if (!ent_q[i].valid) free_idx = IDX_W'(i);
    end
  end

  // Priority select: each port takes the lowest-index ready entry not claimed by a lower port.
  always_comb begin
    logic [NUM_ENTRIES-1:0] avail;
    avail     = ready;
    sel_valid = '0;
    for (int p = 0; p < NUM_ISSUE; p++) begin
      sel_idx[p] = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
        if (avail[i]) begin
          sel_valid[p] = 1'b1;
          sel_idx[p]   = IDX_W'(i);
        end
      end
      if (sel_valid[p]) avail[sel_idx[p]] = 1'b0;
    end
  end

  // Issue port outputs; unused ports drive zeros.
  always_comb begin
    issue_valid    = sel_valid;
    issue_rob_addr = '0;
    issue_dest     = '0;
    issue_op       = '0;
    issue_vj       = '0;
    issue_vk       = '0;
    issue_a        = '0;
    for (int p = 0; p < NUM_ISSUE; p++) begin
      if (sel_valid[p]) begin
        issue_rob_addr[p*ROB_ADDR_W +: ROB_ADDR_W] = ent_q[sel_idx[p]].rob_addr;
        issue_dest[p*DEST_W +: DEST_W]             = ent_q[sel_idx[p]].dest;
        issue_op[p*OP_W +: OP_W]                   = ent_q[sel_idx[p]].op;
        issue_vj[p*DATA_W +: DATA_W]               = ent_q[sel_idx[p]].vj;
        issue_vk[p*DATA_W +: DATA_W]               = ent_q[sel_idx[p]].vk;
        issue_a[p*DATA_W +: DATA_W]                = ent_q[sel_idx[p]].a;
      end
    end
  end

  // Next state: CDB wakeup, issue invalidation, dispatch with same-cycle CDB bypass.
  always_comb begin
    logic [DATA_W:0]  snp;
    logic [CNT_W-1:0] n_issued;
    snp      = '0;
    n_issued = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid && ent_q[i].qj_busy) begin
        snp = snoop(ent_q[i].qj, cdb_valid, cdb_rob_addr, cdb_value);
        if (snp[DATA_W]) begin
          ent_d[i].qj_busy = 1'b0;
          ent_d[i].vj      = snp[DATA_W-1:0];
        end
      end
      if (ent_q[i].valid && ent_q[i].qk_busy) begin
        snp = snoop(ent_q[i].qk, cdb_valid, cdb_rob_addr, cdb_value);
        if (snp[DATA_W]) begin
          ent_d[i].qk_busy = 1'b0;
          ent_d[i].vk      = snp[DATA_W-1:0];
        end
      end
    end
    for (int p = 0; p < NUM_ISSUE; p++) begin
      if (sel_valid[p] && issue_ready[p]) begin
        ent_d[sel_idx[p]].valid = 1'b0;
        n_issued                = n_issued + CNT_W'(1);
      end
    end
    if (disp_fire) begin
      ent_d[free_idx].valid    = 1'b1;
      ent_d[free_idx].rob_addr = disp_rob_addr;
      ent_d[free_idx].dest     = disp_dest;
      ent_d[free_idx].op       = disp_op;
      ent_d[free_idx].qj       = disp_qj;
      ent_d[free_idx].qk       = disp_qk;
      ent_d[free_idx].a        = disp_a;
      ent_d[free_idx].qj_busy  = disp_qj_busy;
      ent_d[free_idx].vj       = disp_vj;
      ent_d[free_idx].qk_busy  = disp_qk_busy;
      ent_d[free_idx].vk       = disp_vk;
      if (disp_qj_busy) begin
        snp = snoop(disp_qj, cdb_valid, cdb_rob_addr, cdb_value);
        if (snp[DATA_W]) begin
          ent_d[free_idx].qj_busy = 1'b0;
          ent_d[free_idx].vj      = snp[DATA_W-1:0];
        end
      end
      if (disp_qk_busy) begin
        snp = snoop(disp_qk, cdb_valid, cdb_rob_addr, cdb_value);
        if (snp[DATA_W]) begin
          ent_d[free_idx].qk_busy = 1'b0;
          ent_d[free_idx].vk      = snp[DATA_W-1:0];
        end
      end
    end
    count_d = count_q + CNT_W'(disp_fire) - n_issued;
  end

  // State update; reset takes priority over flush, flush drops same-cycle dispatch and issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i].valid <= 1'b0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
    end
  end

endmodule
